// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared constants and types for the VGA frame buffer write port.
//   FB_W/FB_H     frame geometry (160x120)
//   X_W/Y_W/A_W   address field widths, FB address is {y, x}
//   OFS_*         bus register offsets from the block base address
//   fill_state_e  fill engine states
//   FG_RST/BG_RST colour register reset values
package vga_fb_pkg;
    localparam int FB_W = 160;
    localparam int FB_H = 120;
    localparam int X_W  = 8;
    localparam int Y_W  = 7;
    localparam int A_W  = X_W + Y_W;

    localparam logic [7:0] OFS_X     = 8'd0;
    localparam logic [7:0] OFS_Y     = 8'd1;
    localparam logic [7:0] OFS_PIXEL = 8'd2;
    localparam logic [7:0] OFS_CTRL  = 8'd3;
    localparam logic [7:0] OFS_FG    = 8'd4;
    localparam logic [7:0] OFS_BG    = 8'd5;
    localparam logic [7:0] OFS_NUM   = 8'd6;

    typedef enum logic {
        IDLE,
        FILL
    } fill_state_e;

    localparam logic [7:0] FG_RST = 8'hFF;
    localparam logic [7:0] BG_RST = 8'h00;
endpackage

// File: rtl/fb_sweep_counter.sv
// fb_sweep_counter: nested x/y position counter over a W x H frame.
//   clk, rst_n    clock, async active-low reset (position 0,0)
//   ld_x, ld_y    load x_in / y_in (independently) on the next edge
//   en            advance one pixel: x+1, wrapping at W-1 into y+1, y wraps at H-1
//   x, y          current position
//   nx, ny        position after this edge (what x/y will become)
//   last          current position is (W-1, H-1)
// An x beyond the frame never matches the wrap point, so it just counts
// modulo 2^X_W with y untouched.
module fb_sweep_counter
    import vga_fb_pkg::*;
#(
    parameter int W = FB_W,
    parameter int H = FB_H
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ld_x,
    input  logic           ld_y,
    input  logic           en,
    input  logic [X_W-1:0] x_in,
    input  logic [Y_W-1:0] y_in,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [X_W-1:0] nx,
    output logic [Y_W-1:0] ny,
    output logic           last
);
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           x_wrap;

    always_comb begin
        x_wrap = x_q == X_W'(W - 1);
        x_d    = ld_x ? x_in : en ? (x_wrap ? '0 : x_q + X_W'(1)) : x_q;
        y_d    = ld_y ? y_in : (en && x_wrap) ? (y_q == Y_W'(H - 1) ? '0 : y_q + Y_W'(1)) : y_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign nx   = x_d;
    assign ny   = y_d;
    assign last = x_wrap && (y_q == Y_W'(H - 1));
endmodule

// File: rtl/vga_fb_writer.sv
// vga_fb_writer: bus-side write port of the 1-bit VGA frame buffer with fill engine.
//   CLK, RESET_N                 clock, async active-low reset
//   BUS_ADDR/DATA_IN/WE/RE       processor bus access, one-cycle strobes
//   BUS_DATA_OUT, BUS_DATA_OE    registered read data, OE high one cycle
//   FB_ADDR, FB_DATA, FB_WE      frame buffer write port, FB_ADDR = {y, x}
//   CONFIG_COLOURS               {FG, BG} colour pair for the signal generator
//   BUSY                         fill engine sweeping the frame
module vga_fb_writer #(
    parameter logic [7:0] BASE_ADDR = 8'hB0,
    parameter int         FB_W      = vga_fb_pkg::FB_W,
    parameter int         FB_H      = vga_fb_pkg::FB_H
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [7:0]  BUS_ADDR,
    input  logic [7:0]  BUS_DATA_IN,
    input  logic        BUS_WE,
    input  logic        BUS_RE,
    output logic [7:0]  BUS_DATA_OUT,
    output logic        BUS_DATA_OE,
    output logic [14:0] FB_ADDR,
    output logic        FB_DATA,
    output logic        FB_WE,
    output logic [15:0] CONFIG_COLOURS,
    output logic        BUSY
);
    import vga_fb_pkg::*;

    localparam logic [X_W-1:0] X_LIM = X_W'(FB_W);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(FB_H);

    fill_state_e    state_q, state_d;
    logic           fill_val_q, fill_val_d;
    logic           autoinc_q, autoinc_d;
    logic [7:0]     fg_q, fg_d, bg_q, bg_d;
    logic           fb_we_q, fb_we_d, fb_data_q, fb_data_d;
    logic [A_W-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]     dout_q, dout_d;
    logic           oe_q, oe_d;

    logic [7:0]     off;
    logic           wr, rd, busy;
    logic           wr_x, wr_y, wr_pix, wr_ctrl;
    logic           fill_start, fill_on, pix_ok, pix_we;
    logic [X_W-1:0] px, fnx;
    logic [Y_W-1:0] py, fny;
    logic           f_last;
    logic [15:0]    pos_unused;
    logic [14:0]    fill_unused;

    // Current X/Y register with the AUTOINC advance.
    fb_sweep_counter #(.W(FB_W), .H(FB_H)) u_pos (
        .clk   (CLK),
        .rst_n (RESET_N),
        .ld_x  (wr_x),
        .ld_y  (wr_y),
        .en    (pix_ok && autoinc_q),
        .x_in  (BUS_DATA_IN),
        .y_in  (BUS_DATA_IN[Y_W-1:0]),
        .x     (px),
        .y     (py),
        .nx    (pos_unused[7:0]),
        .ny    (pos_unused[14:8]),
        .last  (pos_unused[15])
    );

    // Fill sweep position; it tracks the address currently on FB_ADDR, so
    // its next value is the address registered for the following write.
    fb_sweep_counter #(.W(FB_W), .H(FB_H)) u_fill (
        .clk   (CLK),
        .rst_n (RESET_N),
        .ld_x  (fill_start),
        .ld_y  (fill_start),
        .en    (fill_on),
        .x_in  ('0),
        .y_in  ('0),
        .x     (fill_unused[7:0]),
        .y     (fill_unused[14:8]),
        .nx    (fnx),
        .ny    (fny),
        .last  (f_last)
    );

    always_comb begin
        off        = BUS_ADDR - BASE_ADDR;
        wr         = BUS_WE && (off < OFS_NUM);
        rd         = BUS_RE && (off < OFS_NUM);
        busy       = state_q == FILL;
        wr_x       = wr && (off == OFS_X);
        wr_y       = wr && (off == OFS_Y);
        wr_pix     = wr && (off == OFS_PIXEL);
        wr_ctrl    = wr && (off == OFS_CTRL);
        fill_start = wr_ctrl && BUS_DATA_IN[1] && !busy;
        // The last sweep write is already on the port, so stop issuing.
        fill_on    = busy && !f_last;
        pix_ok     = wr_pix && !busy;
        pix_we     = pix_ok && (px < X_LIM) && (py < Y_LIM);
        state_d    = fill_start ? FILL : (busy && f_last) ? IDLE : state_q;
        fill_val_d = fill_start ? BUS_DATA_IN[2] : fill_val_q;
        autoinc_d  = wr_ctrl ? BUS_DATA_IN[0] : autoinc_q;
        fg_d       = (wr && off == OFS_FG) ? BUS_DATA_IN : fg_q;
        bg_d       = (wr && off == OFS_BG) ? BUS_DATA_IN : bg_q;
        fb_we_d    = fill_start || fill_on || pix_we;
        fb_addr_d  = (fill_start || fill_on) ? {fny, fnx} : pix_we ? {py, px} : fb_addr_q;
        fb_data_d  = fill_start ? BUS_DATA_IN[2] : fill_on ? fill_val_q : pix_we ? BUS_DATA_IN[0] : fb_data_q;
        oe_d       = rd;
        dout_d     = !rd                ? 8'h00 :
                     (off == OFS_CTRL)  ? {6'b0, autoinc_q, busy} :
                     (off == OFS_FG)    ? fg_q :
                     (off == OFS_BG)    ? bg_q : 8'h00;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            fill_val_q <= 1'b0;
            autoinc_q  <= 1'b0;
            fg_q       <= FG_RST;
            bg_q       <= BG_RST;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= 1'b0;
            dout_q     <= 8'h00;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_val_q <= fill_val_d;
            autoinc_q  <= autoinc_d;
            fg_q       <= fg_d;
            bg_q       <= bg_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            dout_q     <= dout_d;
            oe_q       <= oe_d;
        end
    end

    assign BUS_DATA_OUT   = dout_q;
    assign BUS_DATA_OE    = oe_q;
    assign FB_ADDR        = fb_addr_q;
    assign FB_DATA        = fb_data_q;
    assign FB_WE          = fb_we_q;
    assign CONFIG_COLOURS = {fg_q, bg_q};
    assign BUSY           = state_q == FILL;
endmodule

// File: doc/vga_fb_writer.md
# vga_fb_writer

Bus-side write port of the 1-bit VGA frame buffer. It turns microprocessor bus accesses into pixel writes on the dual-port RAM's write port, and holds the foreground/background colour pair consumed by the VGA signal generator. It also provides a hardware fill engine that sweeps the full 160×120 frame. The block sits between the processor bus and the frame buffer RAM; the VGA signal generator is the read-side consumer.

## Interface
Parameters:
- BASE_ADDR, 8'hB0, bus base address; the block decodes offsets 0–5.
- FB_W, 160, frame width in pixels.
- FB_H, 120, frame height in pixels.

Ports:
- CLK  in  1  system clock; every register updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- BUS_ADDR  in  8  bus address.
- BUS_DATA_IN  in  8  bus write data.
- BUS_WE  in  1  bus write strobe, one cycle per access.
- BUS_RE  in  1  bus read strobe, one cycle per access.
- BUS_DATA_OUT  out  8  read data.
- BUS_DATA_OE  out  1  high for one cycle while BUS_DATA_OUT is valid.
- FB_ADDR  out  15  frame buffer address, {y[6:0], x[7:0]}.
- FB_DATA  out  1  pixel value to write.
- FB_WE  out  1  frame buffer write enable.
- CONFIG_COLOURS  out  16  [15:8] is the colour for pixel=1, [7:0] is the colour for pixel=0.
- BUSY  out  1  fill engine is active.

## Operation
- Register map, as offsets from BASE_ADDR:
  - +0 X: write-only, 8 bits.
  - +1 Y: write-only, 7 bits; bit 7 is ignored.
  - +2 PIXEL: write commits BUS_DATA_IN[0] at (X,Y).
  - +3 CTRL: write bit0 = AUTOINC (stored); bit1 = FILL start (self-clearing); bit2 = fill value. Read returns {6'b0, AUTOINC, BUSY}.
  - +4 FG: read/write, drives CONFIG_COLOURS[15:8].
  - +5 BG: read/write, drives CONFIG_COLOURS[7:0].
- Reads of offsets 0–2 return 8'h00. Offsets outside 0–5 are ignored, and BUS_DATA_OE stays low for them.
- Pixel write rules:
  - If X≥FB_W or Y≥FB_H, FB_WE is not asserted (write dropped). AUTOINC still advances X/Y.
  - AUTOINC advance: X+1. At X=FB_W−1, X wraps to 0 and Y+1. At Y=FB_H−1 with X=FB_W−1, both wrap to 0.
  - An out-of-range X advances to X+1 modulo 256 and leaves Y unchanged.
- Fill FSM has states IDLE and FILL.
  - IDLE→FILL on a CTRL write with bit1=1. The fill value and sweep counters (fx=0, fy=0) are latched on the same edge.
  - In FILL, one write per cycle: FB_ADDR={fy,fx}, FB_DATA=fill value. fx counts 0..FB_W−1; fy increments on fx wrap.
  - FILL→IDLE after the write at (FB_W−1, FB_H−1).
- While in FILL:
  - PIXEL writes are dropped and X/Y are not advanced.
  - A FILL start is ignored.
  - X, Y, CTRL.AUTOINC, FG and BG writes and all reads proceed normally.
- Reset values:
  - X=0, Y=0, AUTOINC=0.
  - FG=8'hFF, BG=8'h00, so CONFIG_COLOURS=16'hFF00.
  - FSM in IDLE, BUSY=0.
  - FB_WE=0, FB_ADDR=0, FB_DATA=0.
  - BUS_DATA_OUT=0, BUS_DATA_OE=0.
- Asserting RESET_N low mid-fill aborts the fill immediately. FB_WE drops asynchronously, and the frame buffer is left partially filled.

## Timing
- All outputs are registered.
- Bus write at edge n produces FB_WE/FB_ADDR/FB_DATA valid from edge n+1 for exactly one cycle.
- Register updates (X, Y, FG, BG, AUTOINC) are visible from edge n+1. CONFIG_COLOURS changes one cycle after the FG/BG write.
- Read at edge n: BUS_DATA_OUT/BUS_DATA_OE are valid during cycle n+1, then OE returns low.
- Fill:
  - CTRL FILL write at edge n: BUSY=1 from n+1.
  - First FB_WE at n+1 with address 0.
  - Last FB_WE at n+19200 with address {7'd119, 8'd159}.
  - BUSY=0 from n+19201.
  - Exactly 19200 write cycles, no gaps.
- A PIXEL write and a FILL completion in the same cycle: the PIXEL write is dropped, because BUSY was still high when it was sampled.
- Back-to-back PIXEL writes with AUTOINC give one FB_WE per cycle at consecutive addresses.

## Structure
- Shared package vga_fb_pkg holds:
  - FB_W, FB_H, address field widths (7 y bits, 8 x bits).
  - Register offset constants (OFS_X…OFS_BG).
  - Fill state enum {IDLE, FILL}.
  - Colour reset values.
- One sub-module, fb_sweep_counter: nested x/y counter with load, enable, wrap at FB_W−1/FB_H−1, and a last-pixel flag.
  - Used by the fill engine.
  - The AUTOINC X/Y advance reuses the same wrap logic through a second instance.

## Test plan
- Reset: release RESET_N → CONFIG_COLOURS=16'hFF00, FB_WE=0, BUSY=0; read +3 → BUS_DATA_OUT=8'h00 one cycle later with OE=1.
- Write X=5, Y=7, then PIXEL=1 → single FB_WE pulse one cycle after the PIXEL write, FB_ADDR=15'h0705, FB_DATA=1.
- AUTOINC=1, X=159, Y=119, two PIXEL writes → FB_ADDR {119,159} then {0,0}. X=200 PIXEL → no FB_WE, X becomes 201.
- FILL with value 1 → BUSY high for 19200 cycles, 19200 FB_WE pulses covering every address {y<120, x<160} once, no address with x≥160. PIXEL writes and a second FILL during the sweep produce no extra writes.
- Assert RESET_N mid-fill at write 5000 → FB_WE low immediately, BUSY=0 and registers at reset values after release.
- Write FG=8'h1C, BG=8'hE0 → CONFIG_COLOURS=16'h1CE0. Read back +4 returns 8'h1C. Access at BASE+6 gives no OE and no register change.
